// File: rtl/bpu_ftq_pkg.sv
// Shared fetch-target-queue definitions: queue depth, address width and the
// per-block entry layout that the IFU and backend index by ftq_idx.
package bpu_ftq_pkg;

  localparam int FTQ_DEPTH           = 8;
  localparam int FTQ_XLEN            = 32;
  localparam int FTQ_INSTR_PER_FETCH = 4;
  localparam int FTQ_SW              = $clog2(FTQ_INSTR_PER_FETCH);

  // One prediction per fetch block.
  typedef struct packed {
    logic [FTQ_XLEN-1:0] pc;
    logic [FTQ_XLEN-1:0] npc;
    logic                slot_valid;
    logic [FTQ_SW-1:0]   slot_idx;
    logic [FTQ_XLEN-1:0] slot_target;
  } ftq_entry_t;

endpackage

// File: rtl/bpu_ftq.sv
// Fetch target queue between the BPU (producer) and the IFU (consumer).
// Buffers one prediction per fetch block, replays blocks in order and tags
// each with its queue index. flush_i empties the queue.
// Optional feature macro: FTQ_BYPASS_EN -- when the queue is empty an
// incoming prediction is presented to the IFU in the same cycle.
//
// Handshake: a transfer happens on a clock edge where valid && ready are both
// high; valid never waits for ready, and the data presented with valid holds
// stable until the transfer. flush_i cancels any transfer in its cycle.
module bpu_ftq
  import bpu_ftq_pkg::*;
#(
  parameter int DEPTH           = FTQ_DEPTH,
  parameter int XLEN            = FTQ_XLEN,
  parameter int INSTR_PER_FETCH = FTQ_INSTR_PER_FETCH,
  localparam int SW             = $clog2(INSTR_PER_FETCH),
  localparam int IW             = $clog2(DEPTH),
  localparam int PW             = IW + 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            enq_valid_i,
  output logic            enq_ready_o,
  input  logic [XLEN-1:0] enq_pc_i,
  input  logic [XLEN-1:0] enq_npc_i,
  input  logic            enq_slot_valid_i,
  input  logic [SW-1:0]   enq_slot_idx_i,
  input  logic [XLEN-1:0] enq_slot_target_i,
  output logic            deq_valid_o,
  input  logic            deq_ready_i,
  output logic [XLEN-1:0] deq_pc_o,
  output logic [XLEN-1:0] deq_npc_o,
  output logic            deq_slot_valid_o,
  output logic [SW-1:0]   deq_slot_idx_o,
  output logic [XLEN-1:0] deq_slot_target_o,
  output logic [IW-1:0]   deq_ftq_idx_o,
  output logic [PW-1:0]   count_o
);

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  ftq_entry_t    r_mem [DEPTH];

  logic       w_full;
  logic       w_empty;
  logic       w_bypass;
  logic       w_enq_fire;
  logic       w_deq_fire;
  logic       w_write;
  ftq_entry_t w_enq_entry;
  ftq_entry_t w_head;

  assign w_empty = (r_rd_ptr == r_wr_ptr);
  assign w_full  = (r_rd_ptr[IW-1:0] == r_wr_ptr[IW-1:0]) && (r_rd_ptr[IW] != r_wr_ptr[IW]);

  assign w_enq_entry.pc          = enq_pc_i;
  assign w_enq_entry.npc         = enq_npc_i;
  assign w_enq_entry.slot_valid  = enq_slot_valid_i;
  assign w_enq_entry.slot_idx    = enq_slot_idx_i;
  assign w_enq_entry.slot_target = enq_slot_target_i;

`ifdef FTQ_BYPASS_EN
  // Empty queue: the incoming prediction is forwarded straight to the IFU.
  assign w_bypass      = w_empty & enq_valid_i & ~flush_i;
  assign deq_valid_o   = ~w_empty | w_bypass;
  assign w_head        = w_bypass ? w_enq_entry : r_mem[r_rd_ptr[IW-1:0]];
  assign deq_ftq_idx_o = w_bypass ? r_wr_ptr[IW-1:0] : r_rd_ptr[IW-1:0];
`else
  // Head is always served from storage: one cycle minimum latency.
  assign w_bypass      = 1'b0;
  assign deq_valid_o   = ~w_empty;
  assign w_head        = r_mem[r_rd_ptr[IW-1:0]];
  assign deq_ftq_idx_o = r_rd_ptr[IW-1:0];
`endif

  // Ready depends only on registered pointers, never on deq_ready_i.
  assign enq_ready_o = ~w_full;
  assign count_o     = r_wr_ptr - r_rd_ptr;

  assign w_enq_fire = enq_valid_i & ~w_full & ~flush_i;
  assign w_deq_fire = deq_valid_o & deq_ready_i & ~flush_i;
  // A bypassed entry consumed in the same cycle never needs a storage slot.
  assign w_write    = w_enq_fire & ~(w_bypass & deq_ready_i);

  assign deq_pc_o          = w_head.pc;
  assign deq_npc_o         = w_head.npc;
  assign deq_slot_valid_o  = w_head.slot_valid;
  assign deq_slot_idx_o    = w_head.slot_idx;
  assign deq_slot_target_o = w_head.slot_target;

  // Pointer update: reset and flush clear both, otherwise advance on each fire.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
    end else if (flush_i) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
    end else begin
      if (w_enq_fire) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_deq_fire) r_rd_ptr <= r_rd_ptr + PW'(1);
    end
  end

  // Entry storage write; contents are not reset.
  always_ff @(posedge clk_i) begin
    if (w_write) r_mem[r_wr_ptr[IW-1:0]] <= w_enq_entry;
  end

endmodule

// File: tb/tb_bpu_ftq.sv
// Self-checking bench for bpu_ftq: directed scenarios plus random traffic,
// checked by a queue-based reference model in a negedge monitor.
// Honours FTQ_BYPASS_EN in the same way as the design.
module tb_bpu_ftq;
  import bpu_ftq_pkg::*;

  localparam int DEPTH = FTQ_DEPTH;
  localparam int XLEN  = FTQ_XLEN;
  localparam int SW    = FTQ_SW;
  localparam int IW    = $clog2(DEPTH);
  localparam int PW    = IW + 1;
  localparam int W     = 3 * XLEN + 1 + SW + IW;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            flush = 1'b0;
  logic            enq_valid = 1'b0;
  logic            enq_ready;
  logic [XLEN-1:0] enq_pc = '0;
  logic [XLEN-1:0] enq_npc = '0;
  logic            enq_sv = 1'b0;
  logic [SW-1:0]   enq_sidx = '0;
  logic [XLEN-1:0] enq_tgt = '0;
  logic            deq_valid;
  logic            deq_ready = 1'b0;
  logic [XLEN-1:0] deq_pc;
  logic [XLEN-1:0] deq_npc;
  logic            deq_sv;
  logic [SW-1:0]   deq_sidx;
  logic [XLEN-1:0] deq_tgt;
  logic [IW-1:0]   deq_idx;
  logic [PW-1:0]   count;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: queue of {entry, expected ftq_idx}, oldest first.
  logic [W-1:0] exp_q[$];
  int           exp_widx = 0;

  bpu_ftq dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .enq_valid_i(enq_valid), .enq_ready_o(enq_ready),
    .enq_pc_i(enq_pc), .enq_npc_i(enq_npc), .enq_slot_valid_i(enq_sv),
    .enq_slot_idx_i(enq_sidx), .enq_slot_target_i(enq_tgt),
    .deq_valid_o(deq_valid), .deq_ready_i(deq_ready),
    .deq_pc_o(deq_pc), .deq_npc_o(deq_npc), .deq_slot_valid_o(deq_sv),
    .deq_slot_idx_o(deq_sidx), .deq_slot_target_o(deq_tgt),
    .deq_ftq_idx_o(deq_idx), .count_o(count)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Driver tasks
  task automatic set_in(input logic ev, input logic [XLEN-1:0] pc, input logic dr, input logic fl);
    enq_valid = ev;
    enq_pc    = pc;
    enq_npc   = pc + 32'h10;
    enq_sv    = 1'($urandom_range(1));
    enq_sidx  = SW'($urandom_range(FTQ_INSTR_PER_FETCH - 1));
    enq_tgt   = $urandom;
    deq_ready = dr;
    flush     = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    set_in(1'b0, '0, 1'b0, 1'b0);
    repeat (n) tick();
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    set_in(1'b0, '0, 1'b1, 1'b0);
    while (count != 0 && guard < 4 * DEPTH) begin
      tick();
      guard++;
    end
    chk("drain_timeout", 128'(guard < 4 * DEPTH), 128'(1));
    set_in(1'b0, '0, 1'b0, 1'b0);
  endtask

  // Scoreboard monitor: compare outputs with the model, then apply this cycle's transfers.
  always @(negedge clk) begin
    logic [W-1:0] enq_w;
    logic [W-1:0] head;
    logic         exp_valid;
    logic         enq_acc;
    int           sz;
    if (rst) begin
      exp_q.delete();
      exp_widx = 0;
      chk("rst_count", 128'(count), 128'(0));
      chk("rst_ready", 128'(enq_ready), 128'(1));
      chk("rst_valid", 128'(deq_valid), 128'(0));
    end else begin
      sz      = exp_q.size();
      enq_acc = enq_valid && (sz < DEPTH) && !flush;
      enq_w   = {enq_pc, enq_npc, enq_sv, enq_sidx, enq_tgt, IW'(exp_widx)};
`ifdef FTQ_BYPASS_EN
      exp_valid = (sz > 0) || (enq_valid && !flush);
`else
      exp_valid = (sz > 0);
`endif
      chk("count", 128'(count), 128'(sz));
      chk("enq_ready", 128'(enq_ready), 128'(sz < DEPTH));
      chk("deq_valid", 128'(deq_valid), 128'(exp_valid));
      if (exp_valid) begin
        head = (sz > 0) ? exp_q[0] : enq_w;
        chk("deq_data", 128'({deq_pc, deq_npc, deq_sv, deq_sidx, deq_tgt, deq_idx}), 128'(head));
      end
      if (flush) begin
        exp_q.delete();
        exp_widx = 0;
      end else begin
        if (enq_acc) begin
          exp_q.push_back(enq_w);
          exp_widx = (exp_widx + 1) % DEPTH;
        end
        if (exp_valid && deq_ready) void'(exp_q.pop_front());
      end
    end
  end

  // Stimulus
  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    // 1: idle after reset
    idle(2);
    chk("t1_count", 128'(count), 128'(0));
    chk("t1_ready", 128'(enq_ready), 128'(1));
    chk("t1_valid", 128'(deq_valid), 128'(0));

    // 2: three enqueues held, then drained in order with indices 0,1,2
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, 32'h8000_0000 + 32'(i * 16), 1'b0, 1'b0);
      tick();
    end
    set_in(1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t2_pc", 128'(deq_pc), 128'(32'h8000_0000 + 32'(i * 16)));
      chk("t2_idx", 128'(deq_idx), 128'(i));
      @(posedge clk);
      #1;
    end
    idle(1);

    // 3: fill to full, then simultaneous enq+deq while full
    for (int i = 0; i < DEPTH; i++) begin
      set_in(1'b1, 32'h9000_0000 + 32'(i * 16), 1'b0, 1'b0);
      tick();
    end
    set_in(1'b0, '0, 1'b0, 1'b0);
    #1;
    chk("t3_full_ready", 128'(enq_ready), 128'(0));
    chk("t3_full_count", 128'(count), 128'(DEPTH));
    set_in(1'b1, 32'h9100_0000, 1'b1, 1'b0);
    tick();
    set_in(1'b0, '0, 1'b0, 1'b0);
    #1;
    chk("t3_count_after", 128'(count), 128'(DEPTH - 1));
    drain();

    // 4: restart from index 0, stream 11 entries through so the pointers wrap
    set_in(1'b0, '0, 1'b0, 1'b1);
    tick();
    for (int i = 0; i < 11; i++) begin
      set_in(1'b1, 32'hA000_0000 + 32'(i * 16), 1'(i >= 4), 1'b0);
      tick();
    end
    drain();

    // 5: flush with concurrent enqueue and dequeue
    for (int i = 0; i < 5; i++) begin
      set_in(1'b1, 32'hB000_0000 + 32'(i * 16), 1'b0, 1'b0);
      tick();
    end
    chk("t5_count", 128'(count), 128'(5));
    set_in(1'b1, 32'hDEAD_0000, 1'b1, 1'b1);
    tick();
    set_in(1'b0, '0, 1'b0, 1'b0);
    #1;
    chk("t5_flush_count", 128'(count), 128'(0));
    chk("t5_flush_valid", 128'(deq_valid), 128'(0));
    chk("t5_flush_ready", 128'(enq_ready), 128'(1));
    idle(2);

    // 6: empty queue, enqueue with IFU ready
    set_in(1'b1, 32'h0000_1234, 1'b1, 1'b0);
    #1;
`ifdef FTQ_BYPASS_EN
    chk("t6_byp_valid", 128'(deq_valid), 128'(1));
    chk("t6_byp_pc", 128'(deq_pc), 128'(32'h1234));
    tick();
    set_in(1'b0, '0, 1'b0, 1'b0);
    #1;
    chk("t6_byp_count", 128'(count), 128'(0));
`else
    chk("t6_valid_now", 128'(deq_valid), 128'(0));
    tick();
    set_in(1'b0, '0, 1'b1, 1'b0);
    #1;
    chk("t6_valid_next", 128'(deq_valid), 128'(1));
    chk("t6_pc_next", 128'(deq_pc), 128'(32'h1234));
    tick();
    set_in(1'b0, '0, 1'b0, 1'b0);
`endif
    idle(1);

    // Reset asserted with entries buffered and a transfer in flight
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, 32'hC000_0000 + 32'(i * 16), 1'b0, 1'b0);
      tick();
    end
    set_in(1'b0, '0, 1'b1, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_mid_count", 128'(count), 128'(0));
    chk("rst_mid_valid", 128'(deq_valid), 128'(0));
    set_in(1'b0, '0, 1'b0, 1'b0);
    tick();
    rst = 1'b0;
    idle(1);

    // Random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      set_in(1'($urandom_range(99) < 60), $urandom, 1'($urandom_range(99) < 50),
             1'($urandom_range(99) < 3));
      tick();
    end
    drain();
    idle(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global time limit
  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
